// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle event pulses: press, release,
// short click, double click, long press and auto-repeat while held.
module button_event_decoder #(
    parameter int LONG_TIME   = 100_000_000,
    parameter int DCLICK_GAP  = 30_000_000,
    parameter int REPEAT_TIME = 20_000_000,
    parameter int CNT_W       = 27
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clean,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic held,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG
    } state_t;

    // Terminal values compare against the pre-edge count, so a timeout fires
    // exactly PARAM edges after the state was entered.
    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] GAP_TERM    = CNT_W'(DCLICK_GAP - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             clean_q;
    logic             rise;
    logic             fall;

    assign rise = clean & ~clean_q;
    assign fall = ~clean & clean_q;
    assign held = clean_q;
    assign busy = (state != IDLE);

    // Edges on clean are tested before terminal counts so they always win.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            clean_q       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_click   <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            clean_q       <= clean;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_click   <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise) begin
                        state       <= PRESS1;
                        press_pulse <= 1'b1;
                    end
                end

                PRESS1: begin
                    if (fall) begin
                        state         <= WAIT2;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                    end else if (cnt == LONG_TERM) begin
                        state      <= LONG;
                        cnt        <= '0;
                        long_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                WAIT2: begin
                    if (rise) begin
                        state       <= PRESS2;
                        cnt         <= '0;
                        press_pulse <= 1'b1;
                    end else if (cnt == GAP_TERM) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        short_click <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                PRESS2: begin
                    if (fall) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                        double_click  <= 1'b1;
                    end else if (cnt == LONG_TERM) begin
                        state      <= LONG;
                        cnt        <= '0;
                        long_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                LONG: begin
                    if (fall) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                    end else if (cnt == REPEAT_TERM) begin
                        cnt          <= '0;
                        repeat_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with short timing parameters; the
// observed vector is {press, release, short, double, long, repeat, held, busy}.
module tb_button_event_decoder;

    localparam int LONG_T = 20;
    localparam int GAP_T  = 8;
    localparam int REP_T  = 5;

    logic clk;
    logic reset_n;
    logic clean;
    logic press_pulse;
    logic release_pulse;
    logic short_click;
    logic double_click;
    logic long_press;
    logic repeat_pulse;
    logic held;
    logic busy;

    logic [7:0] obs;
    int checks;
    int errors;

    typedef struct {
        logic       clean;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    button_event_decoder #(
        .LONG_TIME  (LONG_T),
        .DCLICK_GAP (GAP_T),
        .REPEAT_TIME(REP_T),
        .CNT_W      (5)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clean        (clean),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_click  (short_click),
        .double_click (double_click),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .busy         (busy)
    );

    assign obs = {press_pulse, release_pulse, short_click, double_click,
                  long_press, repeat_pulse, held, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void add_vec(input logic c, input logic [7:0] e, input int reps);
        for (int i = 0; i < reps; i++) vecs.push_back('{c, e});
    endfunction

    // Drive clean on the falling edge, then look at outputs just after the rising edge.
    task automatic applyStimulus(input logic c);
        @(negedge clk);
        clean = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b (press,rel,short,dbl,long,rep,held,busy)",
                     name, obs, exp);
        end
    endtask

    // Hold clean high for n edges, the first being the rising edge.
    task automatic hold_sequence(input string name, input int n);
        logic is_rep;
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1);
            is_rep = (k > LONG_T) && (((k - LONG_T) % REP_T) == 0);
            checkOutput($sformatf("%s_k%0d", name, k),
                        {k == 0, 1'b0, 1'b0, 1'b0, k == LONG_T, is_rep, 1'b1, 1'b1});
        end
    endtask

    task automatic pulse_reset(input string name);
        reset_n = 1'b0;
        #1;
        checkOutput(name, 8'b0000_0000);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        clean   = 1'b0;

        // single short click, then a double click followed by quiet time
        add_vec(1'b1, 8'b1000_0011, 1);
        add_vec(1'b1, 8'b0000_0011, 4);
        add_vec(1'b0, 8'b0100_0001, 1);
        add_vec(1'b0, 8'b0000_0001, 7);
        add_vec(1'b0, 8'b0010_0000, 1);
        add_vec(1'b0, 8'b0000_0000, 1);
        add_vec(1'b1, 8'b1000_0011, 1);
        add_vec(1'b1, 8'b0000_0011, 3);
        add_vec(1'b0, 8'b0100_0001, 1);
        add_vec(1'b0, 8'b0000_0001, 2);
        add_vec(1'b1, 8'b1000_0011, 1);
        add_vec(1'b1, 8'b0000_0011, 3);
        add_vec(1'b0, 8'b0101_0000, 1);
        add_vec(1'b0, 8'b0000_0000, 9);

        #12;
        checkOutput("reset_state", 8'b0000_0000);
        #1;
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].clean);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // long hold with auto-repeat
        hold_sequence("hold", 47);
        applyStimulus(1'b0);
        checkOutput("hold_release", 8'b0100_0000);
        applyStimulus(1'b0);
        checkOutput("hold_after", 8'b0000_0000);

        // release lands on the long-press terminal edge
        hold_sequence("tie", LONG_T);
        applyStimulus(1'b0);
        checkOutput("tie_release", 8'b0100_0001);
        for (int k = 1; k <= GAP_T; k++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("tie_gap%0d", k), (k == GAP_T) ? 8'b0010_0000 : 8'b0000_0001);
        end
        applyStimulus(1'b0);
        checkOutput("tie_after", 8'b0000_0000);

        // reset while in LONG (long_press still high), then while in WAIT2
        hold_sequence("rst_long", LONG_T + 1);
        pulse_reset("rst_in_long");
        applyStimulus(1'b1);
        checkOutput("rst_repress", 8'b1000_0011);
        applyStimulus(1'b0);
        checkOutput("rst_rel", 8'b0100_0001);
        applyStimulus(1'b0);
        checkOutput("rst_wait2", 8'b0000_0001);
        pulse_reset("rst_in_wait2");
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("rst_no_click%0d", k), 8'b0000_0000);
        end

        // short press, then second press becomes a long hold
        hold_sequence("p1", 3);
        applyStimulus(1'b0);
        checkOutput("p1_rel", 8'b0100_0001);
        applyStimulus(1'b0);
        checkOutput("p1_gap", 8'b0000_0001);
        hold_sequence("p2", 32);
        applyStimulus(1'b0);
        checkOutput("p2_rel", 8'b0100_0000);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("p2_quiet%0d", k), 8'b0000_0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
